// File: rtl/dice_result_stabilizer.sv
// dice_result_stabilizer: debounces per-frame colour classifications into a dice result
//
// Build option: define RELEASE_WHITE_EN so that a fired result re-arms only on the
// rising edge of white_stable. Without it, any frame whose colour differs from the
// last fired colour re-arms.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   frame_done    one-cycle pulse, frame_color valid
//   frame_color   0 NONE, 1 RED, 2 GREEN, 3 BLUE, 4 WHITE, 5..7 read as NONE
//   result_ready  one-cycle pulse with a stable RGB result
//   result_color  01 RED, 10 GREEN, 11 BLUE, held until the next pulse
//   white_stable  level, WHITE face stable
//   sync_lost     level, no frame seen for TIMEOUT_CYCLES
//   debug_cand    current candidate colour
//   debug_count   current consecutive-frame count (saturating)
module dice_result_stabilizer #(
    parameter int STABLE_FRAMES  = 4,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_done,
    input  logic [2:0] frame_color,
    output logic       result_ready,
    output logic [1:0] result_color,
    output logic       white_stable,
    output logic       sync_lost,
    output logic [2:0] debug_cand,
    output logic [7:0] debug_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] SMAX = 8'(STABLE_FRAMES);
    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_WHITE = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_FIRE, S_LOCKED} state_t;

    state_t state_q, state_d;
    logic [2:0] cand_q, cand_d;
    logic [7:0] count_q, count_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0] color_q, color_d;
    logic armed_q, armed_d;
    logic white_q, white_d;
    logic sync_q, sync_d;
    logic [2:0] c;
    logic is_rgb, stable, timeout, fire, rearm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cand_q  <= C_NONE;
            count_q <= '0;
            tmr_q   <= '0;
            color_q <= '0;
            armed_q <= 1'b1;
            white_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            tmr_q   <= tmr_d;
            color_q <= color_d;
            armed_q <= armed_d;
            white_q <= white_d;
            sync_q  <= sync_d;
        end
    end

    // Datapath: frame counting, timeout and re-arm; frame_done always beats a timeout
    always_comb begin
        c       = frame_color > C_WHITE ? C_NONE : frame_color;
        is_rgb  = c != C_NONE && c != C_WHITE;
        timeout = !frame_done && tmr_q >= TMAX - TW'(1);
        tmr_d   = frame_done ? '0 : tmr_q == TMAX ? TMAX : tmr_q + TW'(1);
        cand_d  = frame_done ? c : timeout ? C_NONE : cand_q;
        count_d = frame_done ? (c != cand_q ? 8'd1 : count_q >= SMAX ? SMAX : count_q + 8'd1)
                             : timeout ? 8'd0 : count_q;
        stable  = count_d == SMAX;
        fire    = frame_done && is_rgb && stable && armed_q;
        white_d = frame_done ? c == C_WHITE && (white_q || stable) : !timeout && white_q;
        sync_d  = frame_done ? 1'b0 : timeout || sync_q;
        color_d = state_d == S_FIRE ? c[1:0] : color_q;
`ifdef RELEASE_WHITE_EN
        rearm   = white_d && !white_q;
`else
        rearm   = frame_done && c != {1'b0, color_q};
`endif
        armed_d = rearm ? 1'b1 : state_q == S_FIRE ? 1'b0 : armed_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = frame_done && c != C_NONE ? (fire ? S_FIRE : S_COUNT) : S_IDLE;
            S_COUNT:  state_d = timeout || (frame_done && c == C_NONE) ? S_IDLE
                              : fire ? S_FIRE : S_COUNT;
            S_FIRE:   state_d = timeout ? S_IDLE : S_LOCKED;
            S_LOCKED: state_d = timeout || (frame_done && c == C_NONE) ? S_IDLE
                              : frame_done && c != cand_q ? (fire ? S_FIRE : S_COUNT) : S_LOCKED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_ready = state_q == S_FIRE;
        result_color = color_q;
        white_stable = white_q;
        sync_lost    = sync_q;
        debug_cand   = cand_q;
        debug_count  = count_q;
    end
endmodule

// File: tb/tb_dice_result_stabilizer.sv
// tb_dice_result_stabilizer: directed bench with a frame-level reference model
module tb_dice_result_stabilizer;
    localparam int SF = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_done = 1'b0;
    logic [2:0] frame_color = 3'd0;
    logic result_ready;
    logic [1:0] result_color;
    logic white_stable;
    logic sync_lost;
    logic [2:0] debug_cand;
    logic [7:0] debug_count;

    int checks = 0;
    int errors = 0;
    int dut_pulses[$];
    int mdl_pulses[$];

    dice_result_stabilizer #(.STABLE_FRAMES(SF), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .frame_done(frame_done), .frame_color(frame_color),
        .result_ready(result_ready), .result_color(result_color), .white_stable(white_stable),
        .sync_lost(sync_lost), .debug_cand(debug_cand), .debug_count(debug_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level rules, no state machine
    int m_cand = 0, m_count = 0, m_idle = 0, m_col = 0;
    bit m_armed = 1'b1, m_white = 1'b0, m_sync = 1'b0, m_rdy = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        int cc;
        bit was_pulse, was_white;
        int old_col;
        if (!reset_n) begin
            m_cand = 0; m_count = 0; m_idle = 0; m_col = 0;
            m_armed = 1'b1; m_white = 1'b0; m_sync = 1'b0; m_rdy = 1'b0;
        end else begin
            was_pulse = m_rdy;
            was_white = m_white;
            old_col = m_col;
            m_rdy = 1'b0;
            cc = frame_color > 3'd4 ? 0 : int'(frame_color);
            if (frame_done) begin
                if (cc == m_cand) m_count = m_count + 1 > SF ? SF : m_count + 1;
                else begin
                    m_cand = cc;
                    m_count = 1;
                end
                m_idle = 0;
                m_sync = 1'b0;
                m_white = cc == 4 && (m_white || m_count == SF);
                if (cc >= 1 && cc <= 3 && m_count == SF && m_armed && !was_pulse) begin
                    m_rdy = 1'b1;
                    m_col = cc;
                    mdl_pulses.push_back(cc);
                end
            end else begin
                if (m_idle < TO) m_idle++;
                if (m_idle == TO) begin
                    m_cand = 0; m_count = 0; m_white = 1'b0; m_sync = 1'b1;
                end
            end
`ifdef RELEASE_WHITE_EN
            if (m_white && !was_white) m_armed = 1'b1;
            else if (was_pulse) m_armed = 1'b0;
`else
            if (frame_done && cc != old_col) m_armed = 1'b1;
            else if (was_pulse) m_armed = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        chk("result_ready", int'(result_ready), int'(m_rdy));
        chk("result_color", int'(result_color), m_col);
        chk("white_stable", int'(white_stable), int'(m_white));
        chk("sync_lost", int'(sync_lost), int'(m_sync));
        chk("debug_cand", int'(debug_cand), m_cand);
        chk("debug_count", int'(debug_count), m_count);
        if (result_ready) dut_pulses.push_back(int'(result_color));
    end

    task automatic do_reset();
        reset_n = 1'b0;
        frame_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        dut_pulses.delete();
        mdl_pulses.delete();
    endtask

    task automatic send(input int col);
        frame_color = 3'(col);
        frame_done = 1'b1;
        @(posedge clk);
        #1 frame_done = 1'b0;
        frame_color = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int col, input int n);
        for (int i = 0; i < n; i++) begin
            send(col);
            idle(2);
        end
    endtask

    task automatic chk_pulses(input string name, input int exp[$]);
        chk({name, "_n"}, dut_pulses.size(), exp.size());
        chk({name, "_model_n"}, mdl_pulses.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, i < dut_pulses.size() ? dut_pulses[i] : -1, exp[i]);
    endtask

    initial begin
        int exp5[$];
        @(posedge clk);
        #1 chk("reset_ready", int'(result_ready), 0);
        chk("reset_count", int'(debug_count), 0);

        // T1: four RED frames fire once, further RED frames are silent
        do_reset();
        frames(1, 3);
        send(1);
        chk("t1_ready", int'(result_ready), 1);
        chk("t1_color", int'(result_color), 1);
        idle(1);
        chk("t1_ready_drop", int'(result_ready), 0);
        idle(1);
        frames(1, 6);
        chk_pulses("t1_pulses", '{1});

        // T2: candidate switch restarts the count
        do_reset();
        frames(1, 2);
        send(2);
        chk("t2_count", int'(debug_count), 1);
        chk("t2_cand", int'(debug_cand), 2);
        idle(2);
        frames(2, 3);
        chk_pulses("t2_pulses", '{2});

        // T3: WHITE stability then BLUE
        do_reset();
        frames(4, 3);
        chk("t3_white_pre", int'(white_stable), 0);
        send(4);
        chk("t3_white_set", int'(white_stable), 1);
        idle(2);
        send(3);
        chk("t3_white_clr", int'(white_stable), 0);
        idle(2);
        frames(3, 3);
        chk_pulses("t3_pulses", '{3});

        // T4: frame timeout at exactly TO idle cycles
        do_reset();
        frames(4, 4);
        chk("t4_white", int'(white_stable), 1);
        idle(97);
        chk("t4_sync_early", int'(sync_lost), 0);
        idle(1);
        chk("t4_sync", int'(sync_lost), 1);
        chk("t4_count", int'(debug_count), 0);
        chk("t4_white_clr", int'(white_stable), 0);
        send(1);
        chk("t4_sync_clr", int'(sync_lost), 0);
        chk("t4_count_new", int'(debug_count), 1);
        idle(2);

        // T5: re-arm policy
        do_reset();
        frames(1, 4);
        frames(3, 4);
        frames(4, 4);
        frames(1, 4);
`ifdef RELEASE_WHITE_EN
        exp5 = '{1, 1};
`else
        exp5 = '{1, 3, 1};
`endif
        chk_pulses("t5_pulses", exp5);

        // T6: reset during the pulse cycle, then out-of-range colour
        do_reset();
        frames(1, 3);
        send(1);
        chk("t6_ready", int'(result_ready), 1);
        #1 reset_n = 1'b0;
        #1 chk("t6_rst_ready", int'(result_ready), 0);
        chk("t6_rst_color", int'(result_color), 0);
        chk("t6_rst_count", int'(debug_count), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        dut_pulses.delete();
        mdl_pulses.delete();
        send(6);
        chk("t6_cand_none", int'(debug_cand), 0);
        chk("t6_count_none", int'(debug_count), 1);
        idle(2);
        frames(1, 4);
        chk_pulses("t6_pulses", '{1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
